// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter that shares one SPI SD card read controller between
// up to four requesters. It issues single-sector reads, forwards the 512
// returned bytes to the granted requester, and supervises each read with a
// byte count and an inactivity timeout.
module sd_sector_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int BYTE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_lba,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  done,
  output logic                  error,
  output logic                  busy,
  input  logic                  sd_ready,
  output logic                  sd_read_enable,
  output logic [31:0]           sd_address,
  input  logic [7:0]            sd_data,
  input  logic                  sd_data_ready
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [PW-1:0]   last_q;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic            win_found;
  logic [31:0]     lba_sel;
  logic [31:0]     addr_nxt;

  logic [9:0]      byte_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            sd_data_ready_p0;
  logic            byte_stb;
  logic            count_byte;
  logic            last_byte;
  logic            fin_ok;
  logic            fin_err;
  logic            tmo_active;

  // Stage p0: registered copy of the byte strobe, so a multi-cycle high
  // level from the SD controller is counted exactly once.
  assign byte_stb   = sd_data_ready & ~sd_data_ready_p0;
  assign count_byte = (state == S_STREAM) && byte_stb;
  assign last_byte  = count_byte && (byte_cnt == 10'd511);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_active = (state == S_ISSUE) || (state == S_STREAM) || (state == S_DRAIN);
  assign busy       = (state != S_IDLE);

  // Round-robin search starting just after the most recently granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the winner's sector number and convert it to a CMD17 argument.
  always_comb begin
    lba_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) lba_sel = req_lba[32*i +: 32];
    end
    addr_nxt = (BYTE_ADDR != 0) ? {lba_sel[22:0], 9'd0} : lba_sel;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic plus the end-of-transaction qualifiers.
  always_comb begin
    state_nxt = state;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|req) && sd_ready) state_nxt = S_ARB;
      end
      S_ARB: begin
        state_nxt = win_found ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        if (tmo_hit) begin
          state_nxt = S_IDLE;
          fin_err   = 1'b1;
        end else if (!sd_ready) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_byte) begin
          state_nxt = S_DRAIN;
        end else if (sd_ready || tmo_hit) begin
          // Controller went idle early (short block) or stalled.
          state_nxt = S_IDLE;
          fin_err   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (sd_ready) begin
          state_nxt = S_IDLE;
          fin_ok    = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
          fin_err   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Inactivity timer: restarts on every state change and every counted byte.
  always_ff @(posedge clk) begin
    if (reset || (state_nxt != state) || count_byte || !tmo_active) tmo_cnt <= '0;
    else                                                            tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Grant, address, read-enable, byte forwarding and completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sd_data_ready_p0 <= 1'b0;
      last_q           <= PW'(NUM_REQ - 1);
      gnt              <= '0;
      sd_address       <= '0;
      sd_read_enable   <= 1'b0;
      byte_cnt         <= '0;
      rd_data          <= '0;
      rd_valid         <= 1'b0;
      rd_last          <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      sd_data_ready_p0 <= sd_data_ready;
      rd_valid         <= 1'b0;
      rd_last          <= 1'b0;
      done             <= fin_ok;
      error            <= fin_err;

      // Grant is dropped on the cycle after the done/error pulse.
      if (done || error) gnt <= '0;

      if ((state == S_ARB) && win_found) begin
        gnt            <= NUM_REQ'(1) << win_idx;
        sd_address     <= addr_nxt;
        last_q         <= win_idx;
        sd_read_enable <= 1'b1;
        byte_cnt       <= '0;
      end

      if ((state == S_ISSUE) && (!sd_ready || tmo_hit)) sd_read_enable <= 1'b0;

      // Stage p1: captured byte and its strobe, one cycle after the edge.
      if (count_byte) begin
        rd_data  <= sd_data;
        rd_valid <= 1'b1;
        rd_last  <= (byte_cnt == 10'd511);
        byte_cnt <= byte_cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter with a small behavioural SD controller.
module tb_sd_sector_arbiter;

  localparam int NR  = 2;
  localparam int TMO = 1000;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [32*NR-1:0] req_lba;
  logic            sd_ready;
  logic [7:0]      sd_data;
  logic            sd_data_ready;

  logic [NR-1:0]   gnt;
  logic [7:0]      rd_data;
  logic            rd_valid, rd_last, done, error, busy, sd_read_enable;
  logic [31:0]     sd_address;

  logic [NR-1:0]   g1_gnt;
  logic [7:0]      g1_rd_data;
  logic            g1_rd_valid, g1_rd_last, g1_done, g1_error, g1_busy, g1_sd_read_enable;
  logic [31:0]     g1_sd_address;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  sd_sector_arbiter #(.NUM_REQ(NR), .BYTE_ADDR(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .reset(reset), .req(req), .req_lba(req_lba), .gnt(gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .done(done),
    .error(error), .busy(busy), .sd_ready(sd_ready), .sd_read_enable(sd_read_enable),
    .sd_address(sd_address), .sd_data(sd_data), .sd_data_ready(sd_data_ready)
  );

  sd_sector_arbiter #(.NUM_REQ(NR), .BYTE_ADDR(1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .reset(reset), .req(req), .req_lba(req_lba), .gnt(g1_gnt),
    .rd_data(g1_rd_data), .rd_valid(g1_rd_valid), .rd_last(g1_rd_last), .done(g1_done),
    .error(g1_error), .busy(g1_busy), .sd_ready(sd_ready), .sd_read_enable(g1_sd_read_enable),
    .sd_address(g1_sd_address), .sd_data(sd_data), .sd_data_ready(sd_data_ready)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  // Behavioural SD controller: accepts a read, drops ready, streams bytes
  // with a 2-cycle high strobe and 3-cycle gap, then returns to ready.
  int sd_nbytes  = 512;
  bit sd_respond = 1'b1;
  bit sd_abort   = 1'b0;

  always begin
    @(posedge clk); #1;
    if (sd_respond && sd_read_enable && sd_ready && !reset) begin
      repeat (2) @(posedge clk);
      #1 sd_ready = 1'b0;
      for (int i = 0; i < sd_nbytes; i++) begin
        if (sd_abort) break;
        repeat (3) @(posedge clk);
        #1;
        sd_data       = pat(i);
        sd_data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 sd_data_ready = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 sd_ready = 1'b1;
    end
  end

  // Output monitor for dut0.
  int n_valid, n_last, last_pos, n_done, n_err, data_bad, overlap, bad_pulse, byte_idx;
  logic [NR-1:0] glog [8];

  always @(negedge clk) begin
    if (reset) begin
      byte_idx = 0;
    end else begin
      if (rd_valid) begin
        if (rd_data !== pat(byte_idx)) data_bad++;
        if (rd_last) last_pos = byte_idx;
        byte_idx++;
        n_valid++;
      end
      if (rd_last) n_last++;
      if ($countones(gnt) > 1) overlap++;
      if ((done || error) && (gnt == '0)) bad_pulse++;
      if (done) begin
        if (n_done < 8) glog[n_done] = gnt;
        n_done++;
        byte_idx = 0;
      end
      if (error) begin
        n_err++;
        byte_idx = 0;
      end
    end
  end

  task automatic clr();
    n_valid = 0; n_last = 0; last_pos = -1; n_done = 0; n_err = 0;
    data_bad = 0; overlap = 0; bad_pulse = 0; byte_idx = 0;
    for (int i = 0; i < 8; i++) glog[i] = '0;
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    outs = {gnt, rd_data, rd_valid, rd_last, done, error, busy, sd_read_enable, sd_address};
    chk_cnt++;
    if (outs !== 48'd0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else pass_cnt++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({busy, gnt, sd_read_enable} !== 4'd0) $display("FAIL reset_idle: got %b expected 0000", {busy, gnt, sd_read_enable});
    else pass_cnt++;
  endtask

  task automatic test_single();
    int t;
    clr();
    sd_nbytes = 512; sd_respond = 1'b1;
    req_lba = {32'h0, 32'h10};
    req = 2'b01;
    t = 0; while (gnt == '0 && t < 20) begin @(negedge clk); t++; end
    chk_cnt++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b expected 01", gnt); else pass_cnt++;
    chk_cnt++; if (sd_address !== 32'h10) $display("FAIL single_addr: got %h expected 00000010", sd_address); else pass_cnt++;
    chk_cnt++; if (g1_sd_address !== 32'h2000) $display("FAIL single_byteaddr: got %h expected 00002000", g1_sd_address); else pass_cnt++;
    chk_cnt++; if (sd_read_enable !== 1'b1) $display("FAIL single_sre_high: got %b expected 1", sd_read_enable); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else pass_cnt++;
    t = 0; while (sd_read_enable && t < 50) begin @(negedge clk); t++; end
    chk_cnt++; if ({sd_read_enable, sd_ready} !== 2'b00) $display("FAIL single_sre_drop: got sre/ready %b expected 00", {sd_read_enable, sd_ready}); else pass_cnt++;
    t = 0; while (!done && t < 4000) begin @(negedge clk); t++; end
    chk_cnt++; if (done !== 1'b1) $display("FAIL single_done_seen: got %b expected 1", done); else pass_cnt++;
    chk_cnt++; if (gnt !== 2'b01) $display("FAIL single_gnt_at_done: got %b expected 01", gnt); else pass_cnt++;
    req = 2'b00;
    @(negedge clk);
    chk_cnt++; if (gnt !== 2'b00) $display("FAIL single_gnt_after: got %b expected 00", gnt); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (n_valid !== 512) $display("FAIL single_nvalid: got %0d expected 512", n_valid); else pass_cnt++;
    chk_cnt++; if (n_last !== 1 || last_pos !== 511) $display("FAIL single_last: got %0d at %0d expected 1 at 511", n_last, last_pos); else pass_cnt++;
    chk_cnt++; if (n_done !== 1 || n_err !== 0) $display("FAIL single_pulses: got done %0d err %0d expected 1 0", n_done, n_err); else pass_cnt++;
    chk_cnt++; if (data_bad !== 0) $display("FAIL single_data: got %0d bad bytes expected 0", data_bad); else pass_cnt++;
  endtask

  task automatic test_byte_addr();
    int t;
    clr();
    req_lba = {32'h0, 32'h3};
    req = 2'b01;
    t = 0; while (gnt == '0 && t < 20) begin @(negedge clk); t++; end
    chk_cnt++; if (g1_sd_address !== 32'h600) $display("FAIL byteaddr_addr: got %h expected 00000600", g1_sd_address); else pass_cnt++;
    chk_cnt++; if (sd_address !== 32'h3) $display("FAIL blockaddr_addr: got %h expected 00000003", sd_address); else pass_cnt++;
    t = 0; while (!done && t < 4000) begin @(negedge clk); t++; end
    req = 2'b00;
    chk_cnt++; if (t >= 4000) $display("FAIL byteaddr_done: got timeout expected done"); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int t, k;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clr();
    req_lba = {32'h20, 32'h10};
    req = 2'b11;
    t = 0; k = 0;
    while (k < 3 && t < 12000) begin @(negedge clk); t++; if (done) k++; end
    req = 2'b00;
    chk_cnt++; if (k !== 3) $display("FAIL rr_count: got %0d dones expected 3", k); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({glog[0], glog[1], glog[2]} !== 6'b01_10_01) $display("FAIL rr_order: got %b %b %b expected 01 10 01", glog[0], glog[1], glog[2]);
    else pass_cnt++;
    chk_cnt++; if (overlap !== 0 || bad_pulse !== 0) $display("FAIL rr_onehot: got overlap %0d badpulse %0d expected 0 0", overlap, bad_pulse); else pass_cnt++;
    chk_cnt++; if (n_valid !== 1536 || n_err !== 0) $display("FAIL rr_bytes: got %0d bytes %0d err expected 1536 0", n_valid, n_err); else pass_cnt++;
    chk_cnt++; if (data_bad !== 0) $display("FAIL rr_data: got %0d bad bytes expected 0", data_bad); else pass_cnt++;
  endtask

  task automatic test_short_block();
    int t;
    clr();
    sd_nbytes = 300;
    req_lba = {32'h0, 32'h44};
    req = 2'b01;
    t = 0; while (!error && t < 3000) begin @(negedge clk); t++; end
    chk_cnt++; if (error !== 1'b1) $display("FAIL short_err_seen: got %b expected 1", error); else pass_cnt++;
    chk_cnt++; if (gnt !== 2'b01) $display("FAIL short_gnt_at_err: got %b expected 01", gnt); else pass_cnt++;
    req = 2'b00;
    @(negedge clk);
    chk_cnt++; if ({gnt, busy} !== 3'b000) $display("FAIL short_idle: got gnt/busy %b expected 000", {gnt, busy}); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (n_valid !== 300) $display("FAIL short_nvalid: got %0d expected 300", n_valid); else pass_cnt++;
    chk_cnt++; if (n_done !== 0 || n_err !== 1 || n_last !== 0) $display("FAIL short_pulses: got done %0d err %0d last %0d expected 0 1 0", n_done, n_err, n_last); else pass_cnt++;
    sd_nbytes = 512;
  endtask

  task automatic test_timeout();
    int t;
    clr();
    sd_respond = 1'b0;
    req_lba = {32'h0, 32'h77};
    req = 2'b01;
    t = 0; while (gnt == '0 && t < 20) begin @(negedge clk); t++; end
    chk_cnt++; if (sd_read_enable !== 1'b1) $display("FAIL tmo_sre_high: got %b expected 1", sd_read_enable); else pass_cnt++;
    t = 0; while (!error && t < 1100) begin @(negedge clk); t++; end
    chk_cnt++; if (t !== TMO) $display("FAIL tmo_cycles: got %0d expected %0d", t, TMO); else pass_cnt++;
    chk_cnt++; if ({sd_read_enable, busy} !== 2'b00) $display("FAIL tmo_idle: got sre/busy %b expected 00", {sd_read_enable, busy}); else pass_cnt++;
    chk_cnt++; if (gnt !== 2'b01) $display("FAIL tmo_gnt_at_err: got %b expected 01", gnt); else pass_cnt++;
    req = 2'b00;
    repeat (2) @(negedge clk);
    chk_cnt++; if (gnt !== 2'b00 || n_done !== 0) $display("FAIL tmo_after: got gnt %b done %0d expected 00 0", gnt, n_done); else pass_cnt++;
    sd_respond = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t, k;
    logic [47:0] outs;
    clr();
    req_lba = {32'h0, 32'h10};
    req = 2'b01;
    t = 0; k = 0;
    while (k < 100 && t < 2000) begin @(negedge clk); t++; if (rd_valid) k++; end
    reset = 1'b1; sd_abort = 1'b1; req = 2'b00;
    @(negedge clk);
    outs = {gnt, rd_data, rd_valid, rd_last, done, error, busy, sd_read_enable, sd_address};
    chk_cnt++; if (outs !== 48'd0) $display("FAIL midreset_outputs: got %h expected 0", outs); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    t = 0; while (!sd_ready && t < 50) begin @(negedge clk); t++; end
    sd_abort = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (n_done !== 0 || n_err !== 0) $display("FAIL midreset_pulses: got done %0d err %0d expected 0 0", n_done, n_err); else pass_cnt++;
    req_lba = {32'h55, 32'h0};
    req = 2'b10;
    t = 0; while (gnt == '0 && t < 20) begin @(negedge clk); t++; end
    chk_cnt++; if (gnt !== 2'b10) $display("FAIL midreset_gnt: got %b expected 10", gnt); else pass_cnt++;
    chk_cnt++; if (sd_address !== 32'h55) $display("FAIL midreset_addr: got %h expected 00000055", sd_address); else pass_cnt++;
    t = 0; while (!done && t < 4000) begin @(negedge clk); t++; end
    req = 2'b00;
    repeat (3) @(negedge clk);
    chk_cnt++; if (n_done !== 1 || gnt !== 2'b00) $display("FAIL midreset_next_done: got done %0d gnt %b expected 1 00", n_done, gnt); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_lba = '0;
    sd_ready = 1'b1; sd_data = 8'h00; sd_data_ready = 1'b0;
    clr();
    @(negedge clk);
    test_reset();
    test_single();
    test_byte_addr();
    test_round_robin();
    test_short_block();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares one SPI SD card read controller between up to 4 requesters (e.g. image loader, audio loader).
- Round-robin arbitration; issues single-sector reads and routes the 512 returned bytes to the granted requester.
- Supervises each read with byte counting and a timeout.
- Sits between the requester logic and the SD controller's readEnable/address/dataOut/data_ready/ready interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- BYTE_ADDR, 0, 0 = block-addressed card, sd_address = lba; 1 = byte-addressed card, sd_address = lba << 9 (low 9 bits zero, upper bits truncated to 32).
- TIMEOUT_CYCLES, 50_000_000, idle clk cycles tolerated in ISSUE/STREAM/DRAIN before error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  per-requester read request; level, held until that requester's done pulse.
- req_lba  in  32*NUM_REQ  per-requester sector number; requester i uses bits [32i+31:32i].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- rd_data  out  8  byte to the granted requester.
- rd_valid  out  1  one-cycle strobe per byte; no backpressure, so the requester must accept every strobe.
- rd_last  out  1  high with rd_valid on byte 511.
- done  out  1  one-cycle pulse at the end of a successful transaction, with gnt still valid.
- error  out  1  one-cycle pulse on timeout or short block, with gnt still valid.
- busy  out  1  high in any state except IDLE.
- sd_ready  in  1  SD controller idle and accepting a read.
- sd_read_enable  out  1  read request to the SD controller.
- sd_address  out  32  CMD17 argument.
- sd_data  in  8  byte from the SD controller.
- sd_data_ready  in  1  byte strobe from the SD controller.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Round-robin pointer set so that requester 0 has top priority.
  - Byte counter and timeout counter cleared.
- Reset mid-transaction:
  - Aborts immediately; no done or error pulse.
  - sd_read_enable drops in the same edge.
- States:
  - IDLE: waits until any req bit is high and sd_ready = 1, then goes to ARB.
  - ARB (1 cycle):
    - Picks the first requester with req high, searching upward from (last granted + 1) mod NUM_REQ.
    - Sets gnt, latches that requester's lba into sd_address (BYTE_ADDR rule applied), updates the pointer, goes to ISSUE.
    - If req has dropped by then, returns to IDLE.
  - ISSUE:
    - sd_read_enable = 1 until the first cycle sd_ready = 0 is seen, then drops it and goes to STREAM.
    - sd_address stays stable through ISSUE and STREAM.
  - STREAM:
    - On each rising edge of sd_data_ready (registered previous value, so a multi-cycle high level counts once): rd_data <= sd_data, rd_valid pulses one cycle later, byte counter (10 bits) increments.
    - rd_last accompanies count 511.
    - After byte 511, goes to DRAIN.
    - If sd_ready returns to 1 before 512 bytes, pulses error and goes to IDLE.
  - DRAIN:
    - Waits for sd_ready = 1, then pulses done and goes to IDLE.
    - Extra sd_data_ready edges in DRAIN are ignored; no rd_valid is generated.
  - On the cycle after a done or error pulse, gnt returns to 0.
- Timeout:
  - Counter runs in ISSUE, STREAM and DRAIN.
  - Clears on every state change and on every counted byte.
  - Reaching TIMEOUT_CYCLES pulses error, clears sd_read_enable, and returns to IDLE.
- Grant stability:
  - A req drop mid-transaction is ignored; bytes still stream, done still pulses.
  - A new req arriving mid-transaction waits.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0.
- Throughput: at most one transaction in flight; a new ARB happens no earlier than 1 cycle after done or error.

Test Plan:
- req=01, req_lba0=0x10, BYTE_ADDR=0 -> gnt=01, sd_address=0x00000010, sd_read_enable high until sd_ready falls, 512 rd_valid, rd_last on the 512th, done once, gnt=00 afterwards.
- BYTE_ADDR=1, lba=0x3 -> sd_address=0x00000600.
- req=11 held for 3 transactions -> grant order 0,1,0; done pulses between each, no overlap of gnt bits.
- SD model returns 300 bytes then reasserts sd_ready -> error pulse, no done, rd_valid count 300, state IDLE.
- TIMEOUT_CYCLES=1000, SD model never drops sd_ready -> error at cycle 1000 of ISSUE, sd_read_enable 0, busy 0.
- reset asserted at byte 100 -> next cycle all outputs 0. Then a new req=10 with requester 0 idle -> gnt=10 (pointer reset to favour 0, but only requester 1 requesting).
